fetch_hold_unit: RTL and testbench



---
 rtl/fetch_hold_unit_pkg.sv | 25 ++
 rtl/fetch_hold_unit_if.sv | 34 +++
 rtl/sat_counter.sv | 33 +++
 rtl/fetch_hold_unit.sv | 132 +++++++++++++
 tb/tb_fetch_hold_unit.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_hold_unit_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : fetch_hold_unit_pkg                                  |
// | Description : Shared fetch-stage types and constants               |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
package fetch_hold_unit_pkg;

  // Fetch sequencer states: issue a request, wait for data, hold data.
  typedef enum logic [1:0] {
    FETCH_REQ  = 2'd0,
    FETCH_WAIT = 2'd1,
    HOLD       = 2'd2
  } fetch_state_t;

  // addi x0,x0,0 -- shared with the decoder as the canonical bubble.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Instruction addresses are always word aligned.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_hold_unit_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : fetch_hold_unit_if                                   |
// | Description : Instruction-memory request/grant/rvalid bus          |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
interface fetch_hold_unit_if;

  logic        instr_req_op;
  logic [31:0] instr_addr_op;
  logic        instr_gnt_ip;
  logic        instr_rvalid_ip;
  logic [31:0] instr_rdata_ip;

  // Fetch unit side.
  modport master (
    output instr_req_op,
    output instr_addr_op,
    input  instr_gnt_ip,
    input  instr_rvalid_ip,
    input  instr_rdata_ip
  );

  // Instruction memory side.
  modport slave (
    input  instr_req_op,
    input  instr_addr_op,
    output instr_gnt_ip,
    output instr_rvalid_ip,
    output instr_rdata_ip
  );

endinterface
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : sat_counter                                          |
// | Description : Up-counter that sticks at all-ones                   |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  wire              clk,
  input  wire              reset,
  input  wire              inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] C_MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] C_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_q;

  // Count requested events, freezing once the maximum is reached.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else if (inc && (count_q != C_MAX)) begin
      count_q <= count_q + C_ONE;
    end
  end

  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/fetch_hold_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : fetch_hold_unit                                      |
// | Description : PC, single-outstanding fetch, skid buffer and IF/ID  |
// |               register with stall/flush handling and perf counters |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
module fetch_hold_unit
  import fetch_hold_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          CNT_WIDTH = 32
) (
  input  wire                   clk,
  input  wire                   reset,
  input  wire                   stall_ip,
  input  wire                   branch_taken_ip,
  input  wire  [31:0]           branch_target_ip,
  fetch_hold_unit_if.master     imem,
  output logic [31:0]           ID_instr_op,
  output logic [31:0]           ID_pc_op,
  output logic                  ID_valid_op,
  output logic                  EX_bubble_op,
  output logic [CNT_WIDTH-1:0]  stall_cycles_op,
  output logic [CNT_WIDTH-1:0]  flush_count_op
);

  fetch_state_t state_q;
  logic [31:0]  pc_q;
  logic [31:0]  pc_inflight_q;   // address of the request currently in memory
  logic         drop_q;          // the outstanding response is stale
  logic [31:0]  skid_q;          // occupied exactly while in HOLD
  logic [31:0]  id_instr_q;
  logic [31:0]  id_pc_q;
  logic         id_valid_q;

  // A redirect squashes a request that is (or is becoming) outstanding.
  logic         stale_pending_d;
  assign stale_pending_d = ((state_q == FETCH_WAIT) && !imem.instr_rvalid_ip) ||
                           ((state_q == FETCH_REQ)  &&  imem.instr_gnt_ip);

  // Fetch sequencer plus PC, skid buffer and IF/ID register updates.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= FETCH_REQ;
      pc_q          <= RESET_PC;
      pc_inflight_q <= RESET_PC;
      drop_q        <= 1'b0;
      skid_q        <= NOP_INSTR;
      id_instr_q    <= NOP_INSTR;
      id_pc_q       <= 32'h0000_0000;
      id_valid_q    <= 1'b0;
    end else if (branch_taken_ip) begin
      id_instr_q <= NOP_INSTR;
      id_valid_q <= 1'b0;
      skid_q     <= NOP_INSTR;
      pc_q       <= word_align(branch_target_ip);
      if (stale_pending_d) begin
        state_q <= FETCH_WAIT;
        drop_q  <= 1'b1;
      end else begin
        state_q <= FETCH_REQ;
        drop_q  <= 1'b0;
      end
    end else begin
      // Unstalled IF/ID drains to a bubble unless a new word lands below.
      if (!stall_ip) begin
        id_instr_q <= NOP_INSTR;
        id_valid_q <= 1'b0;
      end
      case (state_q)
        FETCH_REQ: begin
          if (imem.instr_gnt_ip) begin
            pc_inflight_q <= pc_q;
            state_q       <= FETCH_WAIT;
          end
        end
        FETCH_WAIT: begin
          if (imem.instr_rvalid_ip) begin
            state_q <= FETCH_REQ;
            if (drop_q) begin
              drop_q <= 1'b0;
            end else if (!stall_ip) begin
              id_instr_q <= imem.instr_rdata_ip;
              id_pc_q    <= pc_inflight_q;
              id_valid_q <= 1'b1;
              pc_q       <= pc_q + 32'd4;
            end else begin
              skid_q  <= imem.instr_rdata_ip;
              state_q <= HOLD;
            end
          end
        end
        HOLD: begin
          if (!stall_ip) begin
            id_instr_q <= skid_q;
            id_pc_q    <= pc_inflight_q;
            id_valid_q <= 1'b1;
            pc_q       <= pc_q + 32'd4;
            state_q    <= FETCH_REQ;
          end
        end
        default: state_q <= FETCH_REQ;
      endcase
    end
  end

  assign imem.instr_req_op  = (state_q == FETCH_REQ);
  assign imem.instr_addr_op = pc_q;

  assign ID_instr_op  = id_instr_q;
  assign ID_pc_op     = id_pc_q;
  assign ID_valid_op  = id_valid_q;
  assign EX_bubble_op = stall_ip | branch_taken_ip | ~id_valid_q;

  // A flush overrides a stall, so such cycles count only as flushes.
  sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_ip & ~branch_taken_ip),
    .count (stall_cycles_op)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (branch_taken_ip),
    .count (flush_count_op)
  );

endmodule
`default_nettype wire

// File: tb/tb_fetch_hold_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : tb_fetch_hold_unit                                   |
// | Description : Directed bench with behavioural fetch model          |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
module tb_fetch_hold_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        br;
  logic [31:0] tgt;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  always #5 clk = ~clk;

  fetch_hold_unit_if bus0 ();
  fetch_hold_unit_if bus1 ();

  assign bus0.instr_gnt_ip    = gnt;
  assign bus0.instr_rvalid_ip = rvalid;
  assign bus0.instr_rdata_ip  = rdata;
  assign bus1.instr_gnt_ip    = gnt;
  assign bus1.instr_rvalid_ip = rvalid;
  assign bus1.instr_rdata_ip  = rdata;

  logic [31:0] id_instr0, id_pc0, stall_cnt0, flush_cnt0;
  logic        id_valid0, bubble0;
  logic [31:0] id_instr1, id_pc1;
  logic        id_valid1, bubble1;
  logic [3:0]  stall_cnt1, flush_cnt1;

  fetch_hold_unit #(.RESET_PC(32'h0000_0000), .CNT_WIDTH(32)) dut0 (
    .clk(clk), .reset(rst_n), .stall_ip(stall), .branch_taken_ip(br),
    .branch_target_ip(tgt), .imem(bus0),
    .ID_instr_op(id_instr0), .ID_pc_op(id_pc0), .ID_valid_op(id_valid0),
    .EX_bubble_op(bubble0), .stall_cycles_op(stall_cnt0), .flush_count_op(flush_cnt0)
  );

  fetch_hold_unit #(.RESET_PC(32'h0000_0000), .CNT_WIDTH(4)) dut1 (
    .clk(clk), .reset(rst_n), .stall_ip(stall), .branch_taken_ip(br),
    .branch_target_ip(tgt), .imem(bus1),
    .ID_instr_op(id_instr1), .ID_pc_op(id_pc1), .ID_valid_op(id_valid1),
    .EX_bubble_op(bubble1), .stall_cycles_op(stall_cnt1), .flush_count_op(flush_cnt1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem(input logic [31:0] a);
    return 32'h5A00_0003 ^ a;
  endfunction

  // ---------------- behavioural model ----------------
  logic        m_init = 1'b0;
  logic [31:0] m_pc, m_inflight, m_word, m_id_instr, m_id_pc;
  logic        m_busy, m_discard, m_held, m_id_valid;
  int          m_stalls, m_flushes;

  always @(posedge clk) begin
    logic fire, resp, delivered;
    if (!rst_n) begin
      m_pc = 32'h0; m_inflight = 32'h0; m_word = 32'h0;
      m_busy = 1'b0; m_discard = 1'b0; m_held = 1'b0;
      m_id_instr = 32'h13; m_id_pc = 32'h0; m_id_valid = 1'b0;
      m_stalls = 0; m_flushes = 0; m_init = 1'b1;
    end else if (m_init) begin
      fire = !m_busy && !m_held && gnt;
      resp = m_busy && rvalid;
      if (br) begin
        m_flushes++;
        m_id_instr = 32'h13; m_id_valid = 1'b0;
        m_held = 1'b0;
        m_discard = (m_busy && !rvalid) || fire;
        m_busy = m_discard;
        m_pc = {tgt[31:2], 2'b00};
      end else begin
        delivered = 1'b0;
        if (stall) m_stalls++;
        if (resp) begin
          m_busy = 1'b0;
          if (m_discard) m_discard = 1'b0;
          else if (!stall) begin m_id_instr = rdata; m_id_pc = m_inflight; delivered = 1'b1; end
          else begin m_held = 1'b1; m_word = rdata; end
        end else if (m_held && !stall) begin
          m_id_instr = m_word; m_id_pc = m_inflight; m_held = 1'b0; delivered = 1'b1;
        end
        if (fire) begin m_busy = 1'b1; m_inflight = m_pc; end
        if (delivered) begin m_pc = m_pc + 32'd4; m_id_valid = 1'b1; end
        else if (!stall) begin m_id_instr = 32'h13; m_id_valid = 1'b0; end
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(posedge clk) begin
    #1;
    if (m_init) begin
      chk("req",      32'(bus0.instr_req_op), 32'(!m_busy && !m_held));
      chk("addr",     bus0.instr_addr_op, m_pc);
      chk("id_instr", id_instr0, m_id_instr);
      chk("id_pc",    id_pc0, m_id_pc);
      chk("id_valid", 32'(id_valid0), 32'(m_id_valid));
      chk("bubble",   32'(bubble0), 32'(stall | br | !m_id_valid));
      chk("stall_cnt", stall_cnt0, 32'(m_stalls));
      chk("flush_cnt", flush_cnt0, 32'(m_flushes));
      chk("w4_stall_cnt", 32'(stall_cnt1), (m_stalls > 15) ? 32'd15 : 32'(m_stalls));
      chk("w4_flush_cnt", 32'(flush_cnt1), (m_flushes > 15) ? 32'd15 : 32'(m_flushes));
      chk("w4_id_pc",    id_pc1, m_id_pc);
      chk("w4_id_valid", 32'(id_valid1), 32'(m_id_valid));
    end
  end

  // ---------------- memory responder and stimulus ----------------
  logic        gnt_en;
  int          lat;
  logic        rsp_pend;
  int          rsp_cnt;
  logic [31:0] rsp_addr;

  // Apply inputs at a falling edge, cross one rising edge, then schedule
  // the memory response for the next rising edge.
  task automatic step(input logic st, input logic b, input logic [31:0] t);
    logic        granted;
    logic [31:0] gaddr;
    stall   = st;
    br      = b;
    tgt     = t;
    gnt     = gnt_en;
    granted = bus0.instr_req_op && gnt_en;
    gaddr   = bus0.instr_addr_op;
    @(posedge clk);
    if (granted) begin
      rsp_pend = 1'b1;
      rsp_cnt  = lat;
      rsp_addr = gaddr;
    end
    @(negedge clk);
    rvalid = 1'b0;
    rdata  = 32'hDEAD_BEEF;
    if (rsp_pend) begin
      rsp_cnt--;
      if (rsp_cnt == 0) begin
        rvalid   = 1'b1;
        rdata    = mem(rsp_addr);
        rsp_pend = 1'b0;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; stall = 1'b0; br = 1'b0; tgt = 32'h0;
    gnt = 1'b0; rvalid = 1'b0; rdata = 32'hDEAD_BEEF;
    gnt_en = 1'b0; lat = 1; rsp_pend = 1'b0; rsp_cnt = 0; rsp_addr = 32'h0;
    @(negedge clk);
    step(0, 0, 0); step(0, 0, 0);
    // Reset state
    chk("L_rst_req",   32'(bus0.instr_req_op), 32'd1);
    chk("L_rst_addr",  bus0.instr_addr_op, 32'h0);
    chk("L_rst_valid", 32'(id_valid0), 32'd0);
    chk("L_rst_instr", id_instr0, 32'h0000_0013);
    chk("L_rst_idpc",  id_pc0, 32'h0);
    chk("L_rst_cnt",   stall_cnt0 | flush_cnt0, 32'h0);

    // Back-to-back fetches 0,4,8 with gnt tied high, one-cycle latency
    rst_n = 1'b1; gnt_en = 1'b1;
    step(0, 0, 0); step(0, 0, 0);
    chk("L_f0_pc",    id_pc0, 32'h0);
    chk("L_f0_valid", 32'(id_valid0), 32'd1);
    chk("L_f0_instr", id_instr0, 32'h5A00_0003);
    chk("L_f0_addr",  bus0.instr_addr_op, 32'h4);
    step(0, 0, 0); step(0, 0, 0);
    chk("L_f4_pc",    id_pc0, 32'h4);

    // Three stall cycles while pc 4 sits in IF/ID and fetch of 8 returns
    step(1, 0, 0); step(1, 0, 0); step(1, 0, 0);
    chk("L_st_pc",     id_pc0, 32'h4);
    chk("L_st_valid",  32'(id_valid0), 32'd1);
    chk("L_st_req",    32'(bus0.instr_req_op), 32'd0);
    chk("L_st_bubble", 32'(bubble0), 32'd1);
    step(0, 0, 0);
    chk("L_st_rel_pc",    id_pc0, 32'h8);
    chk("L_st_rel_instr", id_instr0, 32'h5A00_000B);
    chk("L_st_cnt",       stall_cnt0, 32'd3);
    step(0, 0, 0); step(0, 0, 0);
    chk("L_f12_pc", id_pc0, 32'hC);

    // Flush to 0x100 while waiting; stale data arrives two cycles later
    lat = 3;
    step(0, 0, 0);
    step(0, 1, 32'h100);
    chk("L_fl_valid", 32'(id_valid0), 32'd0);
    chk("L_fl_instr", id_instr0, 32'h0000_0013);
    chk("L_fl_cnt",   flush_cnt0, 32'd1);
    chk("L_fl_req",   32'(bus0.instr_req_op), 32'd0);
    lat = 1;
    step(0, 0, 0); step(0, 0, 0);
    chk("L_fl_addr",  bus0.instr_addr_op, 32'h100);
    chk("L_fl_req2",  32'(bus0.instr_req_op), 32'd1);
    step(0, 0, 0); step(0, 0, 0);
    chk("L_fl_idpc",  id_pc0, 32'h100);

    // Flush and stall together, target with low bits set, near wrap
    step(1, 1, 32'hFFFF_FFFF);
    chk("L_fs_valid", 32'(id_valid0), 32'd0);
    chk("L_fs_stall", stall_cnt0, 32'd3);
    chk("L_fs_flush", flush_cnt0, 32'd2);
    step(0, 0, 0); step(0, 0, 0); step(0, 0, 0);
    chk("L_wr_idpc", id_pc0, 32'hFFFF_FFFC);
    chk("L_wr_addr", bus0.instr_addr_op, 32'h0);

    // Reset in the middle of a handshake; response arrives during reset
    lat = 2;
    step(0, 0, 0);
    lat = 1; rst_n = 1'b0; gnt_en = 1'b0;
    step(0, 0, 0); step(0, 0, 0);
    chk("L_mr_valid", 32'(id_valid0), 32'd0);
    chk("L_mr_req",   32'(bus0.instr_req_op), 32'd1);
    chk("L_mr_addr",  bus0.instr_addr_op, 32'h0);
    rst_n = 1'b1;
    step(0, 0, 0);
    gnt_en = 1'b1;
    step(0, 0, 0); step(0, 0, 0);
    chk("L_mr_idpc",  id_pc0, 32'h0);
    chk("L_mr_instr", id_instr0, 32'h5A00_0003);

    // Twenty stall cycles: 4-bit counter saturates
    for (int i = 0; i < 20; i++) step(1, 0, 0);
    chk("L_sat_w4",  32'(stall_cnt1), 32'd15);
    chk("L_sat_w32", stall_cnt0, 32'd20);

    // Flush out of HOLD with misaligned target
    step(0, 1, 32'h0000_01FE);
    chk("L_fh_addr",  bus0.instr_addr_op, 32'h1FC);
    chk("L_fh_req",   32'(bus0.instr_req_op), 32'd1);
    chk("L_fh_valid", 32'(id_valid0), 32'd0);
    step(0, 0, 0); step(0, 0, 0);
    chk("L_fh_idpc",  id_pc0, 32'h1FC);

    // Flush in the same cycle as rvalid
    step(0, 0, 0);
    step(0, 1, 32'h300);
    chk("L_fr_req",   32'(bus0.instr_req_op), 32'd1);
    chk("L_fr_addr",  bus0.instr_addr_op, 32'h300);
    chk("L_fr_flush", flush_cnt0, 32'd2);
    step(0, 0, 0); step(0, 0, 0);
    chk("L_fr_idpc",  id_pc0, 32'h300);
    chk("L_fr_instr", id_instr0, 32'h5A00_0303);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
